// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizing, address-width derivation, and the
// Gray/binary conversion helpers used by the read and write pointer controllers.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH      = 8;

  // Memory address width for a power-of-two depth
  function automatic int unsigned fifo_addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Binary to Gray on a 32-bit container; callers narrow the result
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary on a 32-bit container; zero upper bits do not disturb the prefix XOR
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = '0;
    for (int i = 0; i < 32; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO bus: pop request, synchronized write pointer and memory data in;
// read address, Gray read pointer, flags, level and popped word out.
//   master : the FIFO top / memory side that requests pops and supplies data
//   slave  : the read pointer controller
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH
);

  localparam int unsigned ADDR_WIDTH = fifo_addr_width(DEPTH);
  localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1;

  logic                  R_inc;
  logic [PTR_WIDTH-1:0]  sync_gray_wptr;
  logic [DATA_WIDTH-1:0] rd_mem_data;
  logic [ADDR_WIDTH-1:0] R_addr;
  logic [PTR_WIDTH-1:0]  gray_rd_ptr;
  logic                  empty;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_underflow;
  logic [PTR_WIDTH-1:0]  rd_level;

  modport master (
    output R_inc, sync_gray_wptr, rd_mem_data,
    input  R_addr, gray_rd_ptr, empty, rd_data, rd_valid, rd_underflow, rd_level
  );

  modport slave (
    input  R_inc, sync_gray_wptr, rd_mem_data,
    output R_addr, gray_rd_ptr, empty, rd_data, rd_valid, rd_underflow, rd_level
  );

endinterface

// File: rtl/fifo_gray2bin.sv
// Parameterized Gray-to-binary converter.
//   i_gray : Gray-coded value, W bits
//   o_bin  : binary value, W bits (bit i is the XOR of Gray bits W-1..i)
module fifo_gray2bin #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int i = 0; i < int'(W); i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain pointer and flag controller of the asynchronous FIFO.
//   R_CLK, R_RST   : read clock, asynchronous active-low reset
//   bus (slave)    : R_inc pop request, sync_gray_wptr, rd_mem_data in;
//                    R_addr, gray_rd_ptr, empty, rd_data, rd_valid,
//                    rd_underflow, rd_level out
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH
) (
  input  logic           R_CLK,
  input  logic           R_RST,
  fifo_rd_ctrl_if.slave  bus
);

  localparam int unsigned ADDR_WIDTH = fifo_addr_width(DEPTH);
  localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1;

  logic [PTR_WIDTH-1:0]  r_bn_rd_ptr;
  logic [PTR_WIDTH-1:0]  r_gray_rd_ptr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_rd_underflow;

  logic [PTR_WIDTH-1:0]  w_comb_gray;
  logic [PTR_WIDTH-1:0]  w_wptr_bin;
  logic                  w_empty;
  logic                  w_pop;

  // Gray form of the live read pointer; compared against the synchronized write pointer
  assign w_comb_gray = PTR_WIDTH'(bin2gray(32'(r_bn_rd_ptr)));
  assign w_empty     = (w_comb_gray == bus.sync_gray_wptr);
  assign w_pop       = bus.R_inc && !w_empty;

  fifo_gray2bin #(
    .W (PTR_WIDTH)
  ) u_wptr_g2b (
    .i_gray (bus.sync_gray_wptr),
    .o_bin  (w_wptr_bin)
  );

  // Pointer, popped word and strobes; strobes fall back to zero on every non-event cycle
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_bn_rd_ptr    <= '0;
      r_gray_rd_ptr  <= '0;
      r_rd_data      <= '0;
      r_rd_valid     <= 1'b0;
      r_rd_underflow <= 1'b0;
    end else begin
      r_gray_rd_ptr  <= w_comb_gray;
      r_rd_valid     <= w_pop;
      r_rd_underflow <= bus.R_inc && w_empty;
      if (w_pop) begin
        r_bn_rd_ptr <= r_bn_rd_ptr + PTR_WIDTH'(1);
        r_rd_data   <= bus.rd_mem_data;
      end
    end
  end

  assign bus.R_addr       = r_bn_rd_ptr[ADDR_WIDTH-1:0];
  assign bus.gray_rd_ptr  = r_gray_rd_ptr;
  assign bus.empty        = w_empty;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.rd_underflow = r_rd_underflow;
  // Lagging write pointer makes this a conservative occupancy
  assign bus.rd_level     = w_wptr_bin - r_bn_rd_ptr;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed scenarios plus randomized
// pops against a scripted write pointer, checked by an occupancy-count model.
module tb_fifo_rd_ctrl;

  localparam int unsigned D  = 8;
  localparam int unsigned PW = 4;

  logic R_CLK;
  logic R_RST;

  fifo_rd_ctrl_if #(.DATA_WIDTH(8), .DEPTH(D)) bus ();

  fifo_rd_ctrl #(
    .DATA_WIDTH (8),
    .DEPTH      (D)
  ) dut (
    .R_CLK (R_CLK),
    .R_RST (R_RST),
    .bus   (bus)
  );

  // Memory model: combinational read at the DUT's address
  logic [7:0] mem [D];
  assign bus.rd_mem_data = mem[bus.R_addr];

  initial R_CLK = 1'b0;
  always #5 R_CLK = ~R_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: absolute counts of words written and read
  int         wcnt;
  int         rcnt;
  logic [7:0] exp_data;

  function automatic logic [PW-1:0] gray_of(input int cnt);
    logic [PW-1:0] b;
    b = PW'(cnt % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One read-domain cycle, entered and left at a negedge
  task automatic step(input bit inc, input int nwr);
    bit pop;
    int prev;
    for (int k = 0; k < nwr; k++) begin
      if (wcnt - rcnt < int'(D)) begin
        mem[wcnt % D] = 8'($urandom);
        wcnt++;
      end
    end
    bus.sync_gray_wptr = gray_of(wcnt);
    bus.R_inc = inc;
    #1;
    check_eq("empty",  32'(bus.empty),    32'(wcnt == rcnt));
    check_eq("level",  32'(bus.rd_level), 32'(wcnt - rcnt));
    check_eq("r_addr", 32'(bus.R_addr),   32'(rcnt % D));
    pop  = inc && (wcnt != rcnt);
    prev = rcnt;
    if (pop) begin
      exp_data = mem[rcnt % D];
      rcnt++;
    end
    @(posedge R_CLK);
    #1;
    check_eq("rd_valid",  32'(bus.rd_valid),     32'(pop));
    check_eq("underflow", 32'(bus.rd_underflow), 32'(inc && !pop));
    check_eq("rd_data",   32'(bus.rd_data),      32'(exp_data));
    check_eq("gray_rptr", 32'(bus.gray_rd_ptr),  32'(gray_of(prev)));
    @(negedge R_CLK);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once
  task automatic do_reset();
    R_RST = 1'b0;
    bus.R_inc = 1'b0;
    bus.sync_gray_wptr = '0;
    #1;
    wcnt = 0;
    rcnt = 0;
    exp_data = '0;
    check_eq("rst_valid", 32'(bus.rd_valid),     32'd0);
    check_eq("rst_uflow", 32'(bus.rd_underflow), 32'd0);
    check_eq("rst_data",  32'(bus.rd_data),      32'd0);
    check_eq("rst_addr",  32'(bus.R_addr),       32'd0);
    check_eq("rst_gray",  32'(bus.gray_rd_ptr),  32'd0);
    check_eq("rst_empty", 32'(bus.empty),        32'd1);
    check_eq("rst_level", 32'(bus.rd_level),     32'd0);
    @(negedge R_CLK);
    R_RST = 1'b1;
  endtask

  initial begin
    R_RST = 1'b0;
    bus.R_inc = 1'b0;
    bus.sync_gray_wptr = '0;
    for (int i = 0; i < int'(D); i++) mem[i] = '0;
    wcnt = 0;
    rcnt = 0;
    exp_data = '0;
    repeat (2) @(negedge R_CLK);

    // Reset state, then two words available, pop both, then underflow
    do_reset();
    step(1'b0, 2);
    step(1'b1, 0);
    step(1'b1, 0);
    step(1'b1, 0);
    step(1'b0, 0);

    // Full from the read side, drain eight words across the address wrap
    do_reset();
    step(1'b0, 8);
    for (int i = 0; i < 8; i++) step(1'b1, 0);
    step(1'b0, 0);
    step(1'b1, 0);

    // Reset while rd_valid is high with the read pointer at 5
    do_reset();
    step(1'b0, 7);
    for (int i = 0; i < 5; i++) step(1'b1, 0);
    check_eq("pre_rst_valid", 32'(bus.rd_valid), 32'd1);
    check_eq("pre_rst_addr",  32'(bus.R_addr),   32'd5);
    #2;
    do_reset();
    step(1'b0, 1);
    step(1'b1, 0);

    // Random pops against a scripted write pointer
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 60), int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 12; i++) step(1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
